vec_scale: RTL
==============

// Module: vec_scale
// PURPOSE
//  CPU-programmed Avalon-MM accelerator; the write-side counterpart of the dot-product reader.
//  Reads len signed Q16.16 words from src and multiplies each by a Q16.16 scalar.
//  Writes each result to dst over the Avalon master. Element-serial: read i, then write i.
//  In-place operation (src == dst) is therefore safe.
// PARAMETERS
//  none; data/address widths fixed at 32 bits, word stride fixed at 4 bytes.
// PORTS
//  clk                   in   1   sole clock; all state updates on posedge clk
//  rst                   in   1   reset, synchronous, active-high
//  slave_waitrequest     out  1   high while busy (state != IDLE)
//  slave_address         in   4   word offset: 0 start/status, 1 dst, 2 src, 3 scalar, 4 len
//  slave_read            in   1   CPU read strobe
//  slave_readdata        out  32  combinational mux of selected register
//  slave_write           in   1   CPU write strobe
//  slave_writedata       in   32  CPU write data
//  master_waitrequest    in   1   memory stall
//  master_address        out  32  byte address of current access
//  master_read           out  1   read request
//  master_readdata       in   32  returned word
//  master_readdatavalid  in   1   readdata qualifier
//  master_write          out  1   write request
//  master_writedata      out  32  scaled result
// BEHAVIOUR
//  Reset: state=IDLE; dst/src/scalar/len/count, master_address and master_writedata all 0.
//   master_read=0, master_write=0, slave_waitrequest=0 from the cycle after the rst edge.
//   rst mid-operation aborts the transfer at that edge and drops requests; no partial retry.
//  IDLE: slave accepted (waitrequest=0).
//   Write off 1..4 loads the register. Write off 0 (data ignored) = start.
//   Start with len==0: count<=0, stay IDLE, no master traffic.
//   Start with len!=0: count<=0, src_ptr<=src, dst_ptr<=dst -> RD_REQ.
//   Other offsets: writes ignored; reads return 0.
//   Read off 0 returns count. Read off 1..4 returns dst/src/scalar/len.
//  Busy: slave_waitrequest=1; CPU accesses stall until IDLE, then complete normally.
//   A CPU read of off 0 therefore blocks until the job finishes.
//  RD_REQ: master_read=1, master_address=src_ptr. Held stable until master_waitrequest=0, then -> RD_WAIT.
//  RD_WAIT: no requests. On master_readdatavalid: master_writedata<=scale(readdata), -> WR_REQ.
//   readdatavalid in any other state is ignored.
//  WR_REQ: master_write=1, master_address=dst_ptr, master_writedata held stable.
//   On master_waitrequest=0: count<=count+1.
//   If count+1==len -> IDLE.
//   Else src_ptr+=4, dst_ptr+=4 (mod 2^32, wrap silent) -> RD_REQ.
//  master_read and master_write are never high together.
//  Minimum 3 cycles per element (no stalls, readdatavalid 1 cycle after acceptance).
//  scale(x): p = sext64(x) * sext64(scalar), signed 64-bit; result = p[47:16] (truncate, wrap).
//  len is unsigned 32-bit; count compared for equality only.
// CONFIGURATION
//  VSCALE_SAT_EN defined: saturate instead of wrap.
//   If p[63:47] not all equal: 0x7FFFFFFF when p>0, 0x80000000 when p<0.
//  VSCALE_SAT_EN undefined: pure truncation p[47:16]; no saturation logic.
// TESTING
//  1 Reg access: write dst=0x100, src=0x200, scalar=0x00018000, len=3; read back 1..4 -> same values.
//    Read off 7 -> 0.
//  2 Scale: mem[0x200..]=0x00010000, 0x00020000, 0xFFFF0000; scalar 1.5; start.
//    -> mem[0x100..] = 0x00018000, 0x00030000, 0xFFFE8000.
//    -> read off 0 stalls until done, then returns 3.
//    -> exactly 3 reads and 3 writes, strictly alternating.
//  3 Stall: assert master_waitrequest 5 cycles on every request.
//    -> address/read/write/writedata stable throughout; results identical to test 2.
//  4 len=0: start -> no master_read/master_write ever asserted; waitrequest stays 0; off 0 reads 0.
//  5 Overflow: src word 0x7FFF0000, scalar 0x00020000, len 1.
//    -> 0xFFFE0000 without VSCALE_SAT_EN; 0x7FFFFFFF with it.
//  6 Reset mid-op: assert rst during WR_REQ of element 1.
//    -> next cycle master_write=0, slave_waitrequest=0, all registers read 0; dst[1] unwritten.

Source files
------------

// File: rtl/vec_scale.sv
// Avalon-MM vector scaler: dst[i] = src[i] * scalar (signed Q16.16), one element at a time.
// Define VSCALE_SAT_EN to saturate out-of-range products instead of wrapping them.
module vec_scale (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] dst_reg, dst_next;
  logic [31:0] src_reg, src_next;
  logic [31:0] scalar_reg, scalar_next;
  logic [31:0] len_reg, len_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] src_ptr_reg, src_ptr_next;
  logic [31:0] dst_ptr_reg, dst_ptr_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;

  logic        idle;
  logic        start_we;
  logic [4:1]  reg_we;
  logic [31:0] count_inc;

  assign idle      = (state_reg == IDLE);
  assign start_we  = idle && slave_write && (slave_address == 4'd0);
  assign count_inc = count_reg + 32'd1;

  genvar gi;
  generate
    for (gi = 1; gi <= 4; gi++) begin : g_reg_we
      assign reg_we[gi] = idle && slave_write && (slave_address == 4'(gi));
    end
  endgenerate

  // Full 64-bit signed product; the Q16.16 result lives in bits [47:16].
  logic signed [63:0] data_ext;
  logic signed [63:0] scalar_ext;
  logic signed [63:0] product;
  logic [31:0]        scaled;

  assign data_ext   = {{32{master_readdata[31]}}, master_readdata};
  assign scalar_ext = {{32{scalar_reg[31]}}, scalar_reg};
  assign product    = data_ext * scalar_ext;

`ifdef VSCALE_SAT_EN
  logic in_range;
  assign in_range = (product[63:47] == {17{product[63]}});
  always_comb begin
    if (in_range) begin
      scaled = product[47:16];
    end else if (product[63]) begin
      scaled = 32'h8000_0000;
    end else begin
      scaled = 32'h7FFF_FFFF;
    end
  end
`else
  assign scaled = 32'(product >>> 16);
`endif

  always_comb begin
    state_next   = state_reg;
    dst_next     = dst_reg;
    src_next     = src_reg;
    scalar_next  = scalar_reg;
    len_next     = len_reg;
    count_next   = count_reg;
    src_ptr_next = src_ptr_reg;
    dst_ptr_next = dst_ptr_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (reg_we[1]) dst_next    = slave_writedata;
        if (reg_we[2]) src_next    = slave_writedata;
        if (reg_we[3]) scalar_next = slave_writedata;
        if (reg_we[4]) len_next    = slave_writedata;
        if (start_we) begin
          count_next = 32'd0;
          if (len_reg != 32'd0) begin
            src_ptr_next = src_reg;
            dst_ptr_next = dst_reg;
            addr_next    = src_reg;
            state_next   = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!master_waitrequest) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (master_readdatavalid) begin
          wdata_next = scaled;
          addr_next  = dst_ptr_reg;
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!master_waitrequest) begin
          count_next = count_inc;
          if (count_inc == len_reg) begin
            state_next = IDLE;
          end else begin
            src_ptr_next = src_ptr_reg + 32'd4;
            dst_ptr_next = dst_ptr_reg + 32'd4;
            addr_next    = src_ptr_reg + 32'd4;
            state_next   = RD_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      dst_reg     <= 32'd0;
      src_reg     <= 32'd0;
      scalar_reg  <= 32'd0;
      len_reg     <= 32'd0;
      count_reg   <= 32'd0;
      src_ptr_reg <= 32'd0;
      dst_ptr_reg <= 32'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
    end else begin
      state_reg   <= state_next;
      dst_reg     <= dst_next;
      src_reg     <= src_next;
      scalar_reg  <= scalar_next;
      len_reg     <= len_next;
      count_reg   <= count_next;
      src_ptr_reg <= src_ptr_next;
      dst_ptr_reg <= dst_ptr_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
    end
  end

  assign slave_waitrequest = !idle;
  assign master_read       = (state_reg == RD_REQ);
  assign master_write      = (state_reg == WR_REQ);
  assign master_address    = addr_reg;
  assign master_writedata  = wdata_reg;

  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = count_reg;
        4'd1:    slave_readdata = dst_reg;
        4'd2:    slave_readdata = src_reg;
        4'd3:    slave_readdata = scalar_reg;
        4'd4:    slave_readdata = len_reg;
        default: slave_readdata = 32'd0;
      endcase
    end
  end

endmodule
